// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// Receiver FSM encoding and parity mode selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word fall-through.
// Extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance; a pop frees the slot written in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, parity/frame checks
// and a receive FIFO with overrun detection.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          sysclk,
  input  logic                          Reset_n,
  input  logic                          UART_IN,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CPB_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [2:0]    D_LAST    = 3'(DATA_BITS - 1);
  localparam logic [2:0]    S_LAST    = 3'(STOP_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        cyc;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 fall;
  logic                 samp;
  logic                 last_stop;
  logic                 stop_bad;
  logic                 par_x;
  logic                 par_bad;
  logic                 push_req;
  logic                 fifo_empty;

  // Two-flop synchroniser plus edge history
  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= UART_IN;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Sample strobes and end-of-frame verdict
  always_comb begin
    fall      = rx_prev & ~rx_s;
    samp      = (state == START) ? (cyc == HALF_LAST)
                                 : (cyc == CPB_LAST);
    last_stop = (state == STOP) & samp & (bit_cnt == S_LAST);
    stop_bad  = stop_err | ~rx_s;
    par_x     = (^shreg) ^ par_bit;
    par_bad   = 1'b0;
    if (PARITY == PAR_ODD)  par_bad = ~par_x;
    if (PARITY == PAR_EVEN) par_bad = par_x;
    push_req  = last_stop & ~stop_bad & ~par_bad;
  end

  // Receiver FSM with registered error pulses
  always_ff @(posedge sysclk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cyc         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      stop_err    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= push_req & fifo_full & ~rd_en;
      unique case (state)
        IDLE: begin
          cyc      <= '0;
          bit_cnt  <= '0;
          stop_err <= 1'b0;
          if (fall) state <= START;
        end
        START: begin
          if (samp) begin
            cyc   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DATA: begin
          if (samp) begin
            cyc   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == D_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        PAR: begin
          if (samp) begin
            cyc     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        STOP: begin
          if (samp) begin
            cyc <= '0;
            if (last_stop) begin
              bit_cnt    <= '0;
              stop_err   <= 1'b0;
              frame_err  <= stop_bad;
              parity_err <= ~stop_bad & par_bad;
              state      <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              stop_err <= stop_err | ~rx_s;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (Reset_n),
    .push  (push_req),
    .pop   (rd_en),
    .din   (shreg),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 and 8E1 instances,
// 16 clocks per bit, depth-4 FIFO.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       sysclk = 1'b0;
  logic       Reset_n;
  logic       line_n, line_e;
  logic       rd_n, rd_e;
  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e;
  logic       full_n, full_e;
  logic [2:0] cnt_n, cnt_e;
  logic       pe_n, fe_n, oe_n;
  logic       pe_e, fe_e, oe_e;

  int n_chk  = 0;
  int n_fail = 0;
  int pe_cnt_n = 0, fe_cnt_n = 0, oe_cnt_n = 0;
  int pe_cnt_e = 0, fe_cnt_e = 0, oe_cnt_e = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_fifo #(
    .CLK_PER_BIT (CPB),
    .DATA_BITS   (8),
    .PARITY      (0),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) u_n (
    .sysclk      (sysclk),
    .Reset_n     (Reset_n),
    .UART_IN     (line_n),
    .rd_en       (rd_n),
    .rx_data     (data_n),
    .rx_valid    (valid_n),
    .fifo_full   (full_n),
    .rx_count    (cnt_n),
    .parity_err  (pe_n),
    .frame_err   (fe_n),
    .overrun_err (oe_n)
  );

  uart_rx_fifo #(
    .CLK_PER_BIT (CPB),
    .DATA_BITS   (8),
    .PARITY      (2),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) u_e (
    .sysclk      (sysclk),
    .Reset_n     (Reset_n),
    .UART_IN     (line_e),
    .rd_en       (rd_e),
    .rx_data     (data_e),
    .rx_valid    (valid_e),
    .fifo_full   (full_e),
    .rx_count    (cnt_e),
    .parity_err  (pe_e),
    .frame_err   (fe_e),
    .overrun_err (oe_e)
  );

  // Error pulse tallies
  always @(negedge sysclk) begin
    if (pe_n) pe_cnt_n <= pe_cnt_n + 1;
    if (fe_n) fe_cnt_n <= fe_cnt_n + 1;
    if (oe_n) oe_cnt_n <= oe_cnt_n + 1;
    if (pe_e) pe_cnt_e <= pe_cnt_e + 1;
    if (fe_e) fe_cnt_e <= fe_cnt_e + 1;
    if (oe_e) oe_cnt_e <= oe_cnt_e + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) line_e = v;
    else     line_n = v;
  endtask

  // One frame, started just after a rising edge. The stop sample
  // lands 11 clocks into the stop bit; chk probes either side of it.
  task automatic send_frame(input bit sel, input logic [7:0] d,
                            input bit pflip, input logic stopv,
                            input bit chk, input bit pop_stop);
    set_line(sel, 1'b0);
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      wait_cyc(CPB);
    end
    if (sel) begin
      set_line(sel, (^d) ^ pflip);
      wait_cyc(CPB);
    end
    set_line(sel, stopv);
    wait_cyc(10);
    if (chk) check("valid_pre", sel ? valid_e : valid_n, 0);
    if (pop_stop) begin
      if (sel) rd_e = 1'b1;
      else     rd_n = 1'b1;
    end
    wait_cyc(1);
    rd_n = 1'b0;
    rd_e = 1'b0;
    if (chk) begin
      check("valid_lat", sel ? valid_e : valid_n, 1);
      check("data_lat", sel ? data_e : data_n, d);
    end
    set_line(sel, 1'b1);
    wait_cyc(5);
  endtask

  task automatic pop_chk(input bit sel, input logic [7:0] exp);
    check("pop_data", sel ? data_e : data_n, exp);
    if (sel) rd_e = 1'b1;
    else     rd_n = 1'b1;
    wait_cyc(1);
    rd_n = 1'b0;
    rd_e = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    line_n  = 1'b1;
    line_e  = 1'b1;
    rd_n    = 1'b0;
    rd_e    = 1'b0;
    wait_cyc(3);
    check("rst_valid", valid_n, 0);
    check("rst_count", cnt_n, 0);
    check("rst_data", data_n, 0);
    check("rst_full", full_n, 0);
    Reset_n = 1'b1;
    wait_cyc(5);

    // back-to-back 8N1 frames
    send_frame(0, 8'h0C, 0, 1'b1, 1, 0);
    send_frame(0, 8'h08, 0, 1'b1, 0, 0);
    check("b2b_count", cnt_n, 2);
    pop_chk(0, 8'h0C);
    pop_chk(0, 8'h08);
    check("b2b_empty", valid_n, 0);
    check("b2b_errs", pe_cnt_n + fe_cnt_n + oe_cnt_n, 0);

    // even parity: bad then good frames
    send_frame(1, 8'h0C, 1, 1'b1, 0, 0);
    check("par_err", pe_cnt_e, 1);
    check("par_count", cnt_e, 0);
    check("par_no_fe", fe_cnt_e, 0);
    send_frame(1, 8'h0C, 0, 1'b1, 1, 0);
    send_frame(1, 8'h07, 0, 1'b1, 0, 0);
    check("par_ok_cnt", pe_cnt_e, 1);
    pop_chk(1, 8'h0C);
    pop_chk(1, 8'h07);

    // framing error then recovery
    send_frame(0, 8'h33, 0, 1'b0, 0, 0);
    check("frm_err", fe_cnt_n, 1);
    check("frm_count", cnt_n, 0);
    send_frame(0, 8'h55, 0, 1'b1, 1, 0);
    pop_chk(0, 8'h55);
    check("frm_pe", pe_cnt_n, 0);

    // fill, overrun, drain
    for (int i = 1; i <= 3; i++)
      send_frame(0, 8'(i), 0, 1'b1, 0, 0);
    check("fill3_full", full_n, 0);
    send_frame(0, 8'h04, 0, 1'b1, 0, 0);
    check("fill4_full", full_n, 1);
    check("fill4_cnt", cnt_n, 4);
    send_frame(0, 8'h05, 0, 1'b1, 0, 0);
    check("ovr_err", oe_cnt_n, 1);
    check("ovr_cnt", cnt_n, 4);
    for (int i = 1; i <= 4; i++)
      pop_chk(0, 8'(i));
    check("ovr_drained", valid_n, 0);

    // full with simultaneous pop: no overrun
    for (int i = 1; i <= 4; i++)
      send_frame(0, 8'(i), 0, 1'b1, 0, 0);
    send_frame(0, 8'h05, 0, 1'b1, 0, 1);
    check("pp_no_ovr", oe_cnt_n, 1);
    check("pp_cnt", cnt_n, 4);
    check("pp_full", full_n, 1);
    for (int i = 2; i <= 5; i++)
      pop_chk(0, 8'(i));
    check("pp_cnt0", cnt_n, 0);

    // short glitch is a false start
    line_n = 1'b0;
    wait_cyc(4);
    line_n = 1'b1;
    wait_cyc(40);
    check("gl_valid", valid_n, 0);
    check("gl_errs", pe_cnt_n + fe_cnt_n + oe_cnt_n, 2);

    // reset mid-frame
    send_frame(0, 8'h3C, 0, 1'b1, 0, 0);
    check("mr_pre", cnt_n, 1);
    line_n = 1'b0;
    wait_cyc(CPB);
    line_n = 1'b1;
    wait_cyc(CPB);
    line_n = 1'b0;
    wait_cyc(CPB);
    Reset_n = 1'b0;
    line_n  = 1'b1;
    wait_cyc(1);
    check("mr_valid", valid_n, 0);
    check("mr_cnt", cnt_n, 0);
    check("mr_data", data_n, 0);
    check("mr_errs", {pe_n, fe_n, oe_n}, 0);
    Reset_n = 1'b1;
    wait_cyc(40);
    check("mr_idle", cnt_n, 0);
    check("mr_ecnt", pe_cnt_n + fe_cnt_n + oe_cnt_n, 2);
    send_frame(0, 8'hA5, 0, 1'b1, 1, 0);
    pop_chk(0, 8'hA5);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 5208, meaning sysclk cycles per UART bit (minimum 8).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of 2, at least 2).
REQ-006 SHALL have port sysclk, input, 1, the single clock.
REQ-007 SHALL have port Reset_n, input, 1, reset that is synchronous and active-low.
REQ-008 SHALL have port UART_IN, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port rd_en, input, 1, pops the FIFO head.
REQ-010 SHALL have port rx_data, output, DATA_BITS, FIFO head (first-word fall-through).
REQ-011 SHALL have port rx_valid, output, 1, FIFO not empty.
REQ-012 SHALL have port fifo_full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port rx_count, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-014 SHALL have ports parity_err, frame_err and overrun_err, each an output of width 1 that pulses for one cycle.

Function
REQ-015 UART_IN SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
  - IDLE->START on a synchronised falling edge.
  - START->DATA.
  - DATA->PAR if PARITY!=0, else DATA->STOP.
  - PAR->STOP.
  - STOP->IDLE.
REQ-017 In START, the line SHALL be resampled after CLK_PER_BIT/2 cycles; if high, it is a false start: return to IDLE with no error and no push.
REQ-018 Each later bit SHALL be sampled once, CLK_PER_BIT cycles after the previous sample (mid-bit); the bit counter and the cycle counter reset on every state change.
REQ-019 Data SHALL be assembled LSB first into a DATA_BITS shift register.
REQ-020 Parity check SHALL use XOR of the data bits and the parity bit; the check fails if that XOR is not 1 for odd or not 0 for even.
REQ-021 In STOP, STOP_BITS stop bits SHALL be sampled; any stop sample of 0 is a frame error.
REQ-022 End of frame is the cycle of the last stop sample, with three outcomes.
  - Frame error: pulse frame_err and discard the byte.
  - Parity failure, no frame error: pulse parity_err and discard the byte.
  - Otherwise: push the byte; rx_valid is high on the following cycle (latency 1 cycle after the last stop sample).
REQ-023 A valid byte arriving while fifo_full and rd_en=0 SHALL be dropped and overrun_err pulsed; FIFO contents unchanged.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when full; rx_count is then unchanged.
REQ-025 rd_en while empty SHALL be ignored; pointers never underflow.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-027 After STOP the FSM SHALL return to IDLE; back-to-back frames whose start bit immediately follows the stop bit SHALL be received without loss.

Reset
REQ-028 While Reset_n=0 at a sysclk edge, the block SHALL reset to idle.
  - FSM to IDLE; counters and shift register to 0.
  - FIFO emptied; synchroniser flops to 1.
  - rx_valid, fifo_full, all error outputs and rx_count to 0; rx_data to 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse; reception resumes at the next falling edge after release.

Structure
REQ-030 The FSM state encoding and the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) SHALL live in the shared package uart_pkg.
REQ-031 The FIFO SHALL be the sub-module sync_fifo, parameterised by WIDTH and DEPTH with push, pop, full, empty and count; the receiver FSM SHALL be in uart_rx_fifo itself.

Verification
REQ-032 With CLK_PER_BIT=16, 8N1, send 0x0C then 0x08 back-to-back -> rx_valid rises 1 cycle after the first stop sample, rx_data=0x0C; pop -> rx_data=0x08; no error pulses.
REQ-033 With PARITY=2 (even), send 0x0C with parity bit 1 -> parity_err pulses once, rx_count stays 0.
REQ-034 Send a frame with stop bit 0 -> frame_err pulses, nothing pushed; a following valid frame 0x55 -> rx_data=0x55.
REQ-035 With FIFO_DEPTH=4 and no reads, send 0x01..0x05 -> fifo_full after the 4th frame, overrun_err on the 5th; pops return 0x01..0x04. Repeat with rd_en asserted on the 5th push cycle -> no overrun, 0x05 retained.
REQ-036 Apply a low glitch of 4 cycles on UART_IN -> false start, no push, no error.
REQ-037 Assert Reset_n=0 during the DATA state -> all outputs 0 next cycle; the next full frame 0xA5 is received correctly.
